l2_refill_assembler: RTL and testbench

Collects 64-bit memory-NoC read beats for L2 line refills and assembles them into 256-bit cache lines, one buffer per MSHR, with critical-word-first wrap support. It sits between the MEM-NOC read-response channel and the L2 bank data/tag refill path. Beats for different MSHRs may interleave. Completed lines are handed to the bank in round-robin order.

---
 rtl/l2_refill_assembler.sv | 171 +++++++++++++++++
 tb/tb_l2_refill_assembler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_refill_assembler.sv
// Assembles 64-bit MEM-NOC read beats into 256-bit L2 refill lines, one buffer per MSHR,
// with critical-word-first wrap and round-robin hand-off of completed lines to the bank.
module l2_refill_assembler #(
   parameter int unsigned N_MSHR             = 4,
   parameter int unsigned MSHR_ID_WIDTH      = 2,
   parameter int unsigned MEM_DATA_WIDTH     = 64,
   parameter int unsigned CPU_DATA_WIDTH     = 256,
   parameter int unsigned MEM_BURST_LEN      = 4,
   parameter int unsigned BRESP_STATUS_WIDTH = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          alloc_valid,
   input  logic [MSHR_ID_WIDTH-1:0]      alloc_mshr_id,
   input  logic [1:0]                    alloc_start_beat,
   input  logic                          mem_rvalid,
   output logic                          mem_rready,
   input  logic [MSHR_ID_WIDTH-1:0]      mem_rid,
   input  logic [MEM_DATA_WIDTH-1:0]     mem_rdata,
   input  logic [BRESP_STATUS_WIDTH-1:0] mem_rresp,
   input  logic                          mem_rlast,
   output logic                          line_valid,
   input  logic                          line_ready,
   output logic [MSHR_ID_WIDTH-1:0]      line_mshr_id,
   output logic [CPU_DATA_WIDTH-1:0]     line_data,
   output logic                          line_err,
   output logic [N_MSHR-1:0]             busy,
   output logic                          proto_err
);

   typedef enum logic [1:0] {StIdle, StFill, StFull} buf_state_e;

   buf_state_e                state_q [N_MSHR];
   buf_state_e                state_d [N_MSHR];
   logic [1:0]                ptr_q   [N_MSHR];
   logic [1:0]                ptr_d   [N_MSHR];
   logic [2:0]                cnt_q   [N_MSHR];
   logic [2:0]                cnt_d   [N_MSHR];
   logic [MEM_DATA_WIDTH-1:0] data_q  [N_MSHR][MEM_BURST_LEN];
   logic [N_MSHR-1:0]         err_q, err_d;
   logic                      proto_err_q, proto_err_d;
   logic                      gnt_valid_q, gnt_valid_d;
   logic [MSHR_ID_WIDTH-1:0]  gnt_id_q, gnt_id_d;
   logic [MSHR_ID_WIDTH-1:0]  rr_q, rr_d;

   logic                      beat_acc, handshake, wr_en;
   logic [N_MSHR-1:0]         alloc_hit, beat_hit, release_hit, full_nxt;
   logic [MSHR_ID_WIDTH-1:0]  rr_base, idx;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_MSHR; i++) begin
            state_q[i] <= StIdle;
            ptr_q[i]   <= '0;
            cnt_q[i]   <= '0;
            for (int k = 0; k < MEM_BURST_LEN; k++) data_q[i][k] <= '0;
         end
         err_q       <= '0;
         proto_err_q <= 1'b0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         rr_q        <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         proto_err_q <= proto_err_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         rr_q        <= rr_d;
         if (wr_en) data_q[mem_rid][ptr_q[mem_rid]] <= mem_rdata;
      end
   end

   always_comb begin
      beat_acc  = mem_rvalid && mem_rready;
      handshake = gnt_valid_q && line_ready;
      for (int i = 0; i < N_MSHR; i++) begin
         alloc_hit[i]   = alloc_valid && (alloc_mshr_id == MSHR_ID_WIDTH'(i));
         beat_hit[i]    = beat_acc && (mem_rid == MSHR_ID_WIDTH'(i));
         release_hit[i] = handshake && (gnt_id_q == MSHR_ID_WIDTH'(i));
      end
   end

   // Next-state for every buffer; an alloc always wins over a beat seen in IDLE.
   always_comb begin
      wr_en       = 1'b0;
      proto_err_d = proto_err_q;
      err_d       = err_q;
      for (int i = 0; i < N_MSHR; i++) begin
         state_d[i] = state_q[i];
         ptr_d[i]   = ptr_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            StIdle: begin
               if (beat_hit[i]) proto_err_d = 1'b1;
               if (alloc_hit[i]) begin
                  state_d[i] = StFill;
                  ptr_d[i]   = alloc_start_beat;
                  cnt_d[i]   = '0;
                  err_d[i]   = 1'b0;
               end
            end
            StFill: begin
               if (alloc_hit[i]) proto_err_d = 1'b1;
               if (beat_hit[i]) begin
                  wr_en    = 1'b1;
                  ptr_d[i] = ptr_q[i] + 2'd1;
                  cnt_d[i] = cnt_q[i] + 3'd1;
                  err_d[i] = err_q[i] | (mem_rresp != '0) | (mem_rlast != (cnt_q[i] == 3'd3));
                  if (cnt_q[i] == 3'd3) state_d[i] = StFull;
               end
            end
            StFull: begin
               if (release_hit[i]) begin
                  state_d[i] = StIdle;
                  if (alloc_hit[i]) begin
                     state_d[i] = StFill;
                     ptr_d[i]   = alloc_start_beat;
                     cnt_d[i]   = '0;
                     err_d[i]   = 1'b0;
                  end
               end else if (alloc_hit[i]) begin
                  proto_err_d = 1'b1;
               end
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   // Grant is chosen from next-cycle FULL state so a line is presented one cycle after
   // its last beat; it is frozen while the bank stalls.
   always_comb begin
      for (int i = 0; i < N_MSHR; i++) full_nxt[i] = (state_d[i] == StFull);
      rr_d        = rr_q;
      rr_base     = rr_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      idx         = '0;
      if (handshake) begin
         rr_d    = gnt_id_q + MSHR_ID_WIDTH'(1);
         rr_base = gnt_id_q + MSHR_ID_WIDTH'(1);
      end
      if (!(gnt_valid_q && !line_ready)) begin
         gnt_valid_d = 1'b0;
         // Scan from the far end so the candidate nearest rr_base is written last.
         for (int i = N_MSHR - 1; i >= 0; i--) begin
            idx = rr_base + MSHR_ID_WIDTH'(i);
            if (full_nxt[idx]) begin
               gnt_valid_d = 1'b1;
               gnt_id_d    = idx;
            end
         end
      end
   end

   always_comb begin
      mem_rready   = (state_q[mem_rid] != StFull);
      for (int i = 0; i < N_MSHR; i++) busy[i] = (state_q[i] != StIdle);
      line_valid   = gnt_valid_q;
      line_mshr_id = gnt_id_q;
      line_err     = err_q[gnt_id_q];
      proto_err    = proto_err_q;
      for (int k = 0; k < MEM_BURST_LEN; k++) begin
         line_data[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = data_q[gnt_id_q][k];
      end
   end

endmodule

// File: tb/tb_l2_refill_assembler.sv
// Bench for l2_refill_assembler: directed scenarios plus randomized traffic checked
// against a line-level reference model of the refill buffers and round-robin hand-off.
module tb_l2_refill_assembler;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rstn;
   logic         alloc_valid;
   logic [1:0]   alloc_mshr_id;
   logic [1:0]   alloc_start_beat;
   logic         mem_rvalid;
   logic         mem_rready;
   logic [1:0]   mem_rid;
   logic [63:0]  mem_rdata;
   logic [1:0]   mem_rresp;
   logic         mem_rlast;
   logic         line_valid;
   logic         line_ready;
   logic [1:0]   line_mshr_id;
   logic [255:0] line_data;
   logic         line_err;
   logic [3:0]   busy;
   logic         proto_err;

   always #5 clk = ~clk;

   l2_refill_assembler dut (
      .clk              (clk),
      .rstn             (rstn),
      .alloc_valid      (alloc_valid),
      .alloc_mshr_id    (alloc_mshr_id),
      .alloc_start_beat (alloc_start_beat),
      .mem_rvalid       (mem_rvalid),
      .mem_rready       (mem_rready),
      .mem_rid          (mem_rid),
      .mem_rdata        (mem_rdata),
      .mem_rresp        (mem_rresp),
      .mem_rlast        (mem_rlast),
      .line_valid       (line_valid),
      .line_ready       (line_ready),
      .line_mshr_id     (line_mshr_id),
      .line_data        (line_data),
      .line_err         (line_err),
      .busy             (busy),
      .proto_err        (proto_err)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: per MSHR, whether it is allocated, its start beat, the beats
   // received in arrival order, and whether any beat broke the status/framing rules.
   bit          m_alloc [N];
   int          m_start [N];
   logic [63:0] m_beats [N][4];
   int          m_cnt   [N];
   bit          m_bad   [N];
   bit          m_proto;
   int          m_rr;
   bit          m_gv;
   int          m_gid;

   function automatic bit m_full(input int i);
      return m_alloc[i] && (m_cnt[i] == 4);
   endfunction

   function automatic logic [3:0] m_busy();
      logic [3:0] v;
      for (int i = 0; i < N; i++) v[i] = m_alloc[i];
      return v;
   endfunction

   // Beat j of the burst lands in slot (start + j) mod 4.
   function automatic logic [255:0] m_line(input int i);
      logic [255:0] v;
      v = '0;
      for (int j = 0; j < m_cnt[i]; j++) v[((m_start[i] + j) % 4) * 64 +: 64] = m_beats[i][j];
      return v;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < N; i++) begin
         m_alloc[i] = 0;
         m_cnt[i]   = 0;
         m_bad[i]   = 0;
         m_start[i] = 0;
      end
      m_proto = 0;
      m_rr    = 0;
      m_gv    = 0;
      m_gid   = 0;
   endtask

   task automatic step(input bit av, input int aid, input int ast, input bit rv, input int rid,
                       input logic [63:0] rd, input logic [1:0] rr, input bit rl, input bit lr);
      bit exp_rdy, acc, hs, was_alloc_r, was_alloc_a, was_full_a;
      @(negedge clk);
      alloc_valid      = av;
      alloc_mshr_id    = 2'(aid);
      alloc_start_beat = 2'(ast);
      mem_rvalid       = rv;
      mem_rid          = 2'(rid);
      mem_rdata        = rd;
      mem_rresp        = rr;
      mem_rlast        = rl;
      line_ready       = lr;
      #1;
      exp_rdy = !m_full(rid);
      check_eq("mem_rready", mem_rready, exp_rdy);
      check_eq("busy", busy, m_busy());
      check_eq("proto_err", proto_err, m_proto);
      check_eq("line_valid", line_valid, m_gv);
      if (m_gv) begin
         check_eq("line_mshr_id", line_mshr_id, m_gid);
         check_eq("line_data", line_data, m_line(m_gid));
         check_eq("line_err", line_err, m_bad[m_gid]);
      end
      acc         = rv && exp_rdy;
      hs          = m_gv && lr;
      was_alloc_r = m_alloc[rid];
      was_alloc_a = m_alloc[aid];
      was_full_a  = m_full(aid);
      if (hs) begin
         m_alloc[m_gid] = 0;
         m_cnt[m_gid]   = 0;
         m_rr           = (m_gid + 1) % N;
      end
      if (av) begin
         if (!was_alloc_a || (was_full_a && hs && m_gid == aid)) begin
            m_alloc[aid] = 1;
            m_start[aid] = ast;
            m_cnt[aid]   = 0;
            m_bad[aid]   = 0;
         end else begin
            m_proto = 1;
         end
      end
      if (acc) begin
         if (!was_alloc_r) begin
            m_proto = 1;
         end else begin
            m_bad[rid] = m_bad[rid] || (rr != 0) || (rl != (m_cnt[rid] == 3));
            m_beats[rid][m_cnt[rid]] = rd;
            m_cnt[rid]++;
         end
      end
      if (!(m_gv && !lr)) begin
         m_gv = 0;
         for (int off = 0; off < N; off++) begin
            if (!m_gv && m_full((m_rr + off) % N)) begin
               m_gv  = 1;
               m_gid = (m_rr + off) % N;
            end
         end
      end
   endtask

   task automatic idle(input bit lr);
      step(0, 0, 0, 0, 0, 64'h0, 2'd0, 0, lr);
   endtask

   task automatic beat(input int rid, input logic [63:0] d, input logic [1:0] rr, input bit rl,
                       input bit lr);
      step(0, 0, 0, 1, rid, d, rr, rl, lr);
   endtask

   task automatic alloc(input int aid, input int ast, input bit lr);
      step(1, aid, ast, 0, 0, 64'h0, 2'd0, 0, lr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("rst_line_valid", line_valid, 1'b0);
      check_eq("rst_busy", busy, 4'd0);
      check_eq("rst_proto_err", proto_err, 1'b0);
      check_eq("rst_line_data", line_data, 256'd0);
      check_eq("rst_line_mshr_id", line_mshr_id, 2'd0);
      check_eq("rst_line_err", line_err, 1'b0);
      check_eq("rst_mem_rready", mem_rready, 1'b1);
      m_clear();
      alloc_valid = 0;
      mem_rvalid  = 0;
      line_ready  = 0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
   localparam logic [63:0] BA = 64'hAAAA_0000_AAAA_0000;
   localparam logic [63:0] BB = 64'hBBBB_0000_BBBB_0000;
   localparam logic [63:0] BC = 64'hCCCC_0000_CCCC_0000;
   localparam logic [63:0] BD = 64'hDDDD_0000_DDDD_0000;

   initial begin
      rstn = 1'b0;
      alloc_valid = 0; alloc_mshr_id = 0; alloc_start_beat = 0;
      mem_rvalid = 0; mem_rid = 0; mem_rdata = 0; mem_rresp = 0; mem_rlast = 0;
      line_ready = 0;
      m_clear();
      do_reset();

      // In-order fill.
      alloc(1, 0, 0);
      beat(1, B1, 0, 0, 0);
      beat(1, B2, 0, 0, 0);
      beat(1, B3, 0, 0, 0);
      beat(1, B4, 0, 1, 0);
      idle(0);
      check_eq("inorder_valid", line_valid, 1'b1);
      check_eq("inorder_id", line_mshr_id, 2'd1);
      check_eq("inorder_data", line_data, {B4, B3, B2, B1});
      check_eq("inorder_err", line_err, 1'b0);
      idle(1);

      // Critical-word-first wrap.
      alloc(2, 2, 0);
      beat(2, BA, 0, 0, 0);
      beat(2, BB, 0, 0, 0);
      beat(2, BC, 0, 0, 0);
      beat(2, BD, 0, 1, 0);
      idle(0);
      check_eq("wrap_data", line_data, {BB, BA, BD, BC});
      idle(1);

      // Interleave with backpressure.
      do_reset();
      alloc(0, 0, 0);
      alloc(3, 1, 0);
      for (int j = 0; j < 4; j++) begin
         beat(0, 64'(j + 'h100), 0, j == 3, 0);
         beat(3, 64'(j + 'h300), 0, j == 3, 0);
      end
      beat(0, 64'hDEAD, 0, 1, 0);
      check_eq("full_rready", mem_rready, 1'b0);
      for (int j = 0; j < 3; j++) idle(0);
      idle(1);
      check_eq("rr_first", line_mshr_id, 2'd0);
      idle(1);
      check_eq("rr_second", line_mshr_id, 2'd3);
      idle(1);

      // Error reporting.
      alloc(1, 0, 1);
      beat(1, B1, 0, 0, 1);
      beat(1, B2, 2, 0, 1);
      beat(1, B3, 0, 0, 1);
      beat(1, B4, 0, 1, 1);
      idle(0);
      check_eq("resp_err", line_err, 1'b1);
      idle(1);
      alloc(2, 0, 1);
      beat(2, B1, 0, 0, 1);
      beat(2, B2, 0, 0, 1);
      beat(2, B3, 0, 1, 1);
      beat(2, B4, 0, 0, 1);
      idle(0);
      check_eq("rlast_err", line_err, 1'b1);
      idle(1);
      beat(0, B1, 0, 0, 1);
      idle(1);
      check_eq("proto_idle_beat", proto_err, 1'b1);
      alloc(3, 0, 1);
      alloc(3, 1, 1);
      for (int j = 0; j < 3; j++) idle(1);
      check_eq("proto_sticky", proto_err, 1'b1);

      // Release and re-alloc on the same cycle, then reset mid-fill.
      do_reset();
      alloc(1, 0, 0);
      for (int j = 0; j < 4; j++) beat(1, 64'(j + 'h50), 0, j == 3, 0);
      idle(0);
      step(1, 1, 3, 0, 0, 64'h0, 2'd0, 0, 1);
      idle(0);
      check_eq("realloc_busy", busy[1], 1'b1);
      check_eq("realloc_valid", line_valid, 1'b0);
      beat(1, 64'h77, 0, 0, 0);
      do_reset();

      // Randomized traffic: phase 0 avoids protocol violations, later phases do not.
      for (int ph = 0; ph < 3; ph++) begin
         bit clean;
         clean = (ph == 0);
         if (ph != 0) do_reset();
         for (int c = 0; c < 400; c++) begin
            bit av, rv, rl, lr;
            int aid, ast, rid;
            logic [1:0] rr;
            av  = ($urandom_range(0, 3) == 0);
            aid = $urandom_range(0, 3);
            ast = $urandom_range(0, 3);
            if (clean && m_alloc[aid]) av = 0;
            rv  = ($urandom_range(0, 3) != 0);
            rid = $urandom_range(0, 3);
            if (clean && !m_alloc[rid]) begin
               rv = 0;
               for (int k = 0; k < N; k++) if (m_alloc[k]) begin rv = 1; rid = k; end
            end
            rl  = (m_cnt[rid] == 3);
            if (!clean && $urandom_range(0, 7) == 0) rl = !rl;
            rr  = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'd0;
            lr  = ($urandom_range(0, 2) != 0);
            step(av, aid, ast, rv, rid, {$urandom, $urandom}, rr, rl, lr);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
